// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//
// Byte-level UART transmitter fed by the board put-char FSM. A rising edge on
// start_send latches byte_in and frames it onto txd: start bit, 8 data bits
// LSB-first, optional parity bit, then 1 or 2 stop bits. A one-cycle done
// pulse on response[0] tells the upstream FSM it may issue the next byte.
//
// Parameters:
//   CLK_FREQ   clk frequency in Hz
//   BAUD       line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (must be >= 2)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  1 or 2
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high
//   byte_in     byte to send, sampled when a start_send rising edge is seen
//   start_send  request level; only its 0->1 transition starts a frame
//   response    [0] done pulse at end of frame, [1] busy (not IDLE)
//   txd         serial line, idle high
//   overrun     sticky; set when a rising edge arrives while not IDLE

module uart_tx_serializer #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       start_send,
    output logic [1:0] response,
    output logic       txd,
    output logic       overrun
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned TW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY_BIT,
        STOP,
        DONE
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] bit_timer, bit_timer_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [7:0]    shift, shift_next;
    logic          parity_bit, parity_bit_next;
    logic          overrun_next;
    logic          start_q;
    logic          send_edge;
    logic          timer_end;
    logic          txd_next;

    assign send_edge = start_send & ~start_q;
    assign timer_end = (bit_timer == TIMER_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_timer  <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            overrun    <= 1'b0;
            start_q    <= 1'b0;
            txd        <= 1'b1;
            response   <= '0;
        end else begin
            state      <= state_next;
            bit_timer  <= bit_timer_next;
            bit_cnt    <= bit_cnt_next;
            shift      <= shift_next;
            parity_bit <= parity_bit_next;
            overrun    <= overrun_next;
            start_q    <= start_send;
            // Outputs are registered from the next state so the line is
            // glitch-free and txd falls the cycle after the edge is seen.
            txd        <= txd_next;
            response   <= {state_next != IDLE, state_next == DONE};
        end
    end

    always_comb begin
        state_next      = state;
        bit_timer_next  = bit_timer;
        bit_cnt_next    = bit_cnt;
        shift_next      = shift;
        parity_bit_next = parity_bit;
        overrun_next    = overrun;

        if (send_edge && state != IDLE) begin
            overrun_next = 1'b1;
        end

        case (state)
            IDLE: begin
                if (send_edge) begin
                    shift_next      = byte_in;
                    // Parity is taken from the unshifted byte at latch time.
                    parity_bit_next = (PARITY == 1) ? ~^byte_in : ^byte_in;
                    bit_cnt_next    = '0;
                    bit_timer_next  = '0;
                    state_next      = START;
                end
            end
            START: begin
                if (timer_end) begin
                    bit_timer_next = '0;
                    bit_cnt_next   = '0;
                    state_next     = DATA;
                end else begin
                    bit_timer_next = bit_timer + 1'b1;
                end
            end
            DATA: begin
                if (timer_end) begin
                    bit_timer_next = '0;
                    shift_next     = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_next = '0;
                        state_next   = (PARITY != 0) ? PARITY_BIT : STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end else begin
                    bit_timer_next = bit_timer + 1'b1;
                end
            end
            PARITY_BIT: begin
                if (timer_end) begin
                    bit_timer_next = '0;
                    bit_cnt_next   = '0;
                    state_next     = STOP;
                end else begin
                    bit_timer_next = bit_timer + 1'b1;
                end
            end
            STOP: begin
                if (timer_end) begin
                    bit_timer_next = '0;
                    if (bit_cnt == STOP_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = DONE;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end else begin
                    bit_timer_next = bit_timer + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        txd_next = 1'b1;
        case (state_next)
            START:      txd_next = 1'b0;
            DATA:       txd_next = shift_next[0];
            PARITY_BIT: txd_next = parity_bit_next;
            default:    txd_next = 1'b1;
        endcase
    end

endmodule
